// File: rtl/branch_pkg.sv
// Shared definitions for the branch-resolution unit: opcode, func codes,
// default operand width and the comparator flag bundle.
package branch_pkg;

  localparam int          DEF_BITWIDTH = 32;
  localparam logic [3:0]  OPC_BRANCH   = 4'b0010;

  typedef enum logic [3:0] {
    BT    = 4'b0000,
    BNEZ  = 4'b0001,
    BEQZ  = 4'b0010,
    BF    = 4'b0011,
    BNE   = 4'b0101,
    BEQ   = 4'b0110,
    BLTEZ = 4'b1000,
    BLT   = 4'b1001,
    BGTE  = 4'b1010,
    BGT   = 4'b1011,
    BLTE  = 4'b1100,
    BLTZ  = 4'b1101,
    BGTEZ = 4'b1110,
    BGTZ  = 4'b1111
  } branch_func_e;

  typedef struct packed {
    logic eq;
    logic lt;
    logic zero;
    logic neg;
  } cmp_flags_t;

endpackage

// File: rtl/branch_compare.sv
// Signed operand comparator. zero/neg look only at a, so zero-compare
// branches never see b.
module branch_compare
  import branch_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH
) (
  input  logic [BITWIDTH-1:0] a,
  input  logic [BITWIDTH-1:0] b,
  output cmp_flags_t          flags
);

  always_comb begin
    flags.eq   = (a == b);
    flags.lt   = ($signed(a) < $signed(b));
    flags.zero = (a == '0);
    flags.neg  = a[BITWIDTH-1];
  end

endmodule

// File: rtl/take_branch_unit.sv
// Execute-stage branch resolution: same-cycle taken plus registered copies.
// Define BRANCH_STATS_EN to add saturating branch/taken counters.
module take_branch_unit
  import branch_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          opcode,
  input  logic [3:0]          func,
  input  logic [BITWIDTH-1:0] src_data0,
  input  logic [BITWIDTH-1:0] src_data1,
  output logic                taken,
  output logic                taken_q,
  output logic                branch_q,
`ifdef BRANCH_STATS_EN
  output logic [31:0]         branch_count,
  output logic [31:0]         taken_count,
`endif
  output logic                illegal_func_q
);

  cmp_flags_t flags;
  logic       is_branch;
  logic       illegal;

  branch_compare #(.BITWIDTH(BITWIDTH)) u_cmp (
    .a     (src_data0),
    .b     (src_data1),
    .flags (flags)
  );

  assign is_branch = (opcode == OPC_BRANCH);

  // each arm reads only the flags its condition needs, so X on an unused
  // operand stays out of taken
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    if (is_branch) begin
      case (func)
        BT:      taken = 1'b1;
        BF:      taken = 1'b0;
        BEQ:     taken = flags.eq;
        BNE:     taken = !flags.eq;
        BLT:     taken = flags.lt;
        BLTE:    taken = flags.lt | flags.eq;
        BGTE:    taken = !flags.lt;
        BGT:     taken = !flags.lt & !flags.eq;
        BEQZ:    taken = flags.zero;
        BNEZ:    taken = !flags.zero;
        BLTZ:    taken = flags.neg;
        BLTEZ:   taken = flags.neg | flags.zero;
        BGTEZ:   taken = !flags.neg;
        BGTZ:    taken = !flags.neg & !flags.zero;
        default: illegal = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taken_q        <= 1'b0;
      branch_q       <= 1'b0;
      illegal_func_q <= 1'b0;
    end else begin
      taken_q        <= taken;
      branch_q       <= is_branch;
      illegal_func_q <= illegal;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_count <= '0;
      taken_count  <= '0;
    end else begin
      if (is_branch && branch_count != 32'hFFFF_FFFF)
        branch_count <= branch_count + 32'd1;
      if (taken && taken_count != 32'hFFFF_FFFF)
        taken_count <= taken_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_take_branch_unit.sv
// Directed bench for take_branch_unit; counter checks compile in when
// BRANCH_STATS_EN is defined.
module tb_take_branch_unit;
  import branch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  opcode;
  logic [3:0]  func;
  logic [31:0] src_data0;
  logic [31:0] src_data1;
  logic        taken;
  logic        taken_q;
  logic        branch_q;
  logic        illegal_func_q;
`ifdef BRANCH_STATS_EN
  logic [31:0] branch_count;
  logic [31:0] taken_count;
`endif

  int npass  = 0;
  int ntotal = 0;

  take_branch_unit #(.BITWIDTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .opcode         (opcode),
    .func           (func),
    .src_data0      (src_data0),
    .src_data1      (src_data1),
    .taken          (taken),
    .taken_q        (taken_q),
    .branch_q       (branch_q),
`ifdef BRANCH_STATS_EN
    .branch_count   (branch_count),
    .taken_count    (taken_count),
`endif
    .illegal_func_q (illegal_func_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // inputs change just after the falling edge, comb output sampled 1 unit later
  task automatic drive(input logic [3:0] op, input logic [3:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    opcode = op; func = fn; src_data0 = a; src_data1 = b;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; opcode = 4'd0; func = 4'd0; src_data0 = '0; src_data1 = '0;
    #1;
    check("rst_taken_q", {31'd0, taken_q}, 32'd0);
    check("rst_branch_q", {31'd0, branch_q}, 32'd0);
    check("rst_illegal_q", {31'd0, illegal_func_q}, 32'd0);
    @(negedge clk); reset = 1'b0;

    drive(4'b1100, 4'b0010, 32'd1, 32'd2);
    check("add_taken", {31'd0, taken}, 32'd0);
    tick;
    check("add_taken_q", {31'd0, taken_q}, 32'd0);
    check("add_branch_q", {31'd0, branch_q}, 32'd0);

    drive(4'b0010, 4'b1001, 32'd1, 32'd2);
    check("blt_taken", {31'd0, taken}, 32'd1);
    tick;
    check("blt_taken_q", {31'd0, taken_q}, 32'd1);
    check("blt_branch_q", {31'd0, branch_q}, 32'd1);
    check("blt_illegal_q", {31'd0, illegal_func_q}, 32'd0);

    drive(4'b0010, 4'b1011, 32'd1, 32'd2);
    check("bgt_1_2", {31'd0, taken}, 32'd0);
    drive(4'b0010, 4'b1010, 32'd5, 32'd5);
    check("bgte_eq", {31'd0, taken}, 32'd1);
    drive(4'b0010, 4'b0101, 32'd5, 32'd5);
    check("bne_eq", {31'd0, taken}, 32'd0);
    drive(4'b0010, 4'b0110, 32'd5, 32'd5);
    check("beq_eq", {31'd0, taken}, 32'd1);
    drive(4'b0010, 4'b1100, 32'd5, 32'd5);
    check("blte_eq", {31'd0, taken}, 32'd1);
    drive(4'b0010, 4'b1001, 32'd5, 32'd5);
    check("blt_eq", {31'd0, taken}, 32'd0);
    drive(4'b0010, 4'b1011, 32'd5, 32'd5);
    check("bgt_eq", {31'd0, taken}, 32'd0);
    drive(4'b0010, 4'b1011, 32'd7, 32'hFFFF_FFFE);
    check("bgt_pos_neg", {31'd0, taken}, 32'd1);

    drive(4'b0010, 4'b1101, 32'hFFFF_FFFF, 32'd0);
    check("bltz_m1", {31'd0, taken}, 32'd1);
    drive(4'b0010, 4'b1110, 32'hFFFF_FFFF, 32'd0);
    check("bgtez_m1", {31'd0, taken}, 32'd0);
    drive(4'b0010, 4'b0001, 32'hFFFF_FFFF, 32'd0);
    check("bnez_m1", {31'd0, taken}, 32'd1);

    drive(4'b0010, 4'b1001, 32'h8000_0000, 32'h7FFF_FFFF);
    check("blt_min_max", {31'd0, taken}, 32'd1);
    drive(4'b0010, 4'b1011, 32'h8000_0000, 32'h7FFF_FFFF);
    check("bgt_min_max", {31'd0, taken}, 32'd0);

    drive(4'b0010, 4'b0010, 32'd0, 32'd9);
    check("beqz_0", {31'd0, taken}, 32'd1);
    drive(4'b0010, 4'b1000, 32'd0, 32'd9);
    check("bltez_0", {31'd0, taken}, 32'd1);
    drive(4'b0010, 4'b1111, 32'd0, 32'd9);
    check("bgtz_0", {31'd0, taken}, 32'd0);
    drive(4'b0010, 4'b1111, 32'd3, 32'd9);
    check("bgtz_3", {31'd0, taken}, 32'd1);

    drive(4'b0010, 4'b0010, 32'd0, 32'hxxxx_xxxx);
    check("beqz_bx", {31'd0, taken}, 32'd1);
    drive(4'b0010, 4'b1101, 32'd4, 32'hxxxx_xxxx);
    check("bltz_bx", {31'd0, taken}, 32'd0);

    drive(4'b0010, 4'b0000, 32'd1, 32'd2);
    check("bt", {31'd0, taken}, 32'd1);
    drive(4'b0010, 4'b0011, 32'd1, 32'd2);
    check("bf", {31'd0, taken}, 32'd0);
    drive(4'b0110, 4'b0000, 32'd1, 32'd2);
    check("nonbr_bt", {31'd0, taken}, 32'd0);

    drive(4'b0010, 4'b0111, 32'd1, 32'd2);
    check("illegal_taken", {31'd0, taken}, 32'd0);
    tick;
    check("illegal_q", {31'd0, illegal_func_q}, 32'd1);
    check("illegal_branch_q", {31'd0, branch_q}, 32'd1);
    check("illegal_taken_q", {31'd0, taken_q}, 32'd0);

    drive(4'b0010, 4'b1001, 32'd1, 32'd2);
    tick;
    check("pre_rst_taken_q", {31'd0, taken_q}, 32'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_taken_q", {31'd0, taken_q}, 32'd0);
    check("mid_rst_branch_q", {31'd0, branch_q}, 32'd0);
    check("mid_rst_illegal_q", {31'd0, illegal_func_q}, 32'd0);
`ifdef BRANCH_STATS_EN
    check("mid_rst_branch_cnt", branch_count, 32'd0);
    check("mid_rst_taken_cnt", taken_count, 32'd0);
`endif
    #1 reset = 1'b0;
    tick;
    check("post_rst_taken_q", {31'd0, taken_q}, 32'd1);
    check("post_rst_branch_q", {31'd0, branch_q}, 32'd1);
`ifdef BRANCH_STATS_EN
    check("post_rst_branch_cnt", branch_count, 32'd1);
    check("post_rst_taken_cnt", taken_count, 32'd1);
    drive(4'b0010, 4'b0011, 32'd1, 32'd2);
    tick;
    check("bf_branch_cnt", branch_count, 32'd2);
    check("bf_taken_cnt", taken_count, 32'd1);
`endif

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
